// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: shift-in / capture / shift-out sequencer for one mux-scan chain
module scan_chain_ctrl #(
  parameter int   CHAIN_LEN = 8,
  parameter logic FILL      = 1'b0,
  parameter int   CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] capture_data
);
  typedef enum logic [1:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT} state_t;
  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CHAIN_LEN-1:0] sh;
  logic                 last;
  always_comb last = cnt == CNT_W'(CHAIN_LEN - 1);
  // sh holds the not-yet-driven pattern bits on the way in and the SO samples on the way out
  always_ff @(posedge CK or posedge RST)
    if (RST) begin
      state        <= IDLE;
      SE           <= 1'b0;
      SI           <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      capture_data <= '0;
      cnt          <= '0;
      sh           <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (start) begin
            state <= SHIFT_IN;
            sh    <= {pattern[CHAIN_LEN-2:0], 1'b0};
            SE    <= 1'b1;
            SI    <= pattern[CHAIN_LEN-1];
            busy  <= 1'b1;
            cnt   <= '0;
          end
        SHIFT_IN:
          if (last) begin
            state <= CAPTURE;
            SE    <= 1'b0;
            SI    <= FILL;
            cnt   <= '0;
          end else begin
            SI  <= sh[CHAIN_LEN-1];
            sh  <= {sh[CHAIN_LEN-2:0], 1'b0};
            cnt <= cnt + CNT_W'(1);
          end
        CAPTURE: begin
          state <= SHIFT_OUT;
          SE    <= 1'b1;
          SI    <= FILL;
        end
        SHIFT_OUT: begin
          sh <= {sh[CHAIN_LEN-2:0], SO};
          if (last) begin
            capture_data <= {sh[CHAIN_LEN-2:0], SO};
            state        <= IDLE;
            SE           <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b1;
            cnt          <= '0;
          end else
            cnt <= cnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: randomized self-checking bench with behavioural mux-scan chains (D=~Q)
module tb_scan_chain_ctrl;
  localparam int N = 4;
  logic CK = 1'b0, RST = 1'b0, start = 1'b0;
  logic [N-1:0] pattern = '0;
  logic se0, si0, busy0, done0, se1, si1, busy1, done1;
  logic [N-1:0] cap0, cap1, ch0, ch1, exp_cap;
  int total = 0, bad = 0;

  always #5 CK = ~CK;

  always @(posedge CK) ch0 <= se0 ? {ch0[N-2:0], si0} : ~ch0;
  always @(posedge CK) ch1 <= se1 ? {ch1[N-2:0], si1} : ~ch1;

  scan_chain_ctrl #(.CHAIN_LEN(N)) u0 (
    .CK(CK), .RST(RST), .start(start), .pattern(pattern), .SO(ch0[N-1]),
    .SE(se0), .SI(si0), .busy(busy0), .done(done0), .capture_data(cap0));
  scan_chain_ctrl #(.CHAIN_LEN(N), .FILL(1'b1)) u1 (
    .CK(CK), .RST(RST), .start(start), .pattern(pattern), .SO(ch1[N-1]),
    .SE(se1), .SI(si1), .busy(busy1), .done(done1), .capture_data(cap1));

  task automatic test_reset();
    RST = 1'b1;
    #1;
    total++;
    if ({se0, si0, busy0, done0, cap0} !== '0) begin
      bad++;
      $display("FAIL reset got se=%b si=%b busy=%b done=%b cap=%b exp all 0", se0, si0, busy0, done0, cap0);
    end
    @(posedge CK);
    @(negedge CK);
    RST = 1'b0;
    exp_cap = '0;
    @(negedge CK);
  endtask

  // One sequence; glitch = step at which a start pulse (pattern 1111) arrives while busy,
  // abort = step at which RST is asserted (-1 disables either)
  task automatic run(input logic [N-1:0] p, input int glitch, input int abort);
    logic [N-1:0] prev = exp_cap;
    logic e_se, e_si, e_si1, e_busy, e_done;
    logic [N-1:0] e_cap;
    start = 1'b1;
    pattern = p;
    @(posedge CK);
    @(negedge CK);
    start = 1'b0;
    for (int j = 0; j <= 2 * N + 1; j++) begin
      if (j == abort) begin
        RST = 1'b1;
        #1;
        total++;
        if ({se0, busy0, done0, cap0} !== '0) begin
          bad++;
          $display("FAIL abort_reset j=%0d got se=%b busy=%b done=%b cap=%b exp 0", j, se0, busy0, done0, cap0);
        end
        @(posedge CK);
        @(negedge CK);
        RST = 1'b0;
        exp_cap = '0;
        return;
      end
      e_se   = (j < N) || (j > N && j <= 2 * N);
      e_si   = (j < N) ? p[N-1-j] : 1'b0;
      e_si1  = (j < N) ? p[N-1-j] : 1'b1;
      e_busy = j <= 2 * N;
      e_done = j == 2 * N + 1;
      e_cap  = e_done ? ~p : prev;
      total++;
      if ({se0, si0, busy0, done0} !== {e_se, e_si, e_busy, e_done}) begin
        bad++;
        $display("FAIL ctrl j=%0d got se,si,busy,done=%b%b%b%b exp %b%b%b%b", j, se0, si0, busy0, done0, e_se, e_si, e_busy, e_done);
      end
      total++;
      if (cap0 !== e_cap) begin
        bad++;
        $display("FAIL capture_data j=%0d got=%b exp=%b", j, cap0, e_cap);
      end
      total++;
      if ({se1, si1} !== {e_se, e_si1}) begin
        bad++;
        $display("FAIL fill1_se_si j=%0d got=%b%b exp=%b%b", j, se1, si1, e_se, e_si1);
      end
      if (j == N) begin
        total++;
        if (ch0 !== p) begin
          bad++;
          $display("FAIL chain_after_shift_in got=%b exp=%b", ch0, p);
        end
      end
      if (j == N + 1) begin
        total++;
        if (ch0 !== ~p) begin
          bad++;
          $display("FAIL chain_after_capture got=%b exp=%b", ch0, ~p);
        end
      end
      if (j == 2 * N + 1) begin
        total++;
        if ({ch0, ch1, cap1} !== {{N{1'b0}}, {N{1'b1}}, ~p}) begin
          bad++;
          $display("FAIL end_state got ch0=%b ch1=%b cap1=%b exp %b %b %b", ch0, ch1, cap1, {N{1'b0}}, {N{1'b1}}, ~p);
        end
      end
      if (j == glitch) begin
        start = 1'b1;
        pattern = 4'b1111;
      end else
        start = 1'b0;
      if (j < 2 * N + 1) begin
        @(posedge CK);
        @(negedge CK);
      end
    end
    start = 1'b0;
    exp_cap = ~p;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge CK);
  endtask

  task automatic test_basic();
    run(4'b1010, -1, -1);
    idle(2);
    run(4'b0001, -1, -1);
    idle(1);
  endtask

  task automatic test_start_while_busy();
    run(4'b1010, 3, -1);
    idle(3);
    total++;
    if ({busy0, done0, cap0} !== {2'b00, 4'b0101}) begin
      bad++;
      $display("FAIL busy_start_ignored got busy=%b done=%b cap=%b exp 0 0 0101", busy0, done0, cap0);
    end
  endtask

  task automatic test_back_to_back();
    run(4'b1010, -1, -1);
    run(4'b1100, -1, -1);
    idle(1);
  endtask

  task automatic test_reset_mid_op();
    run(4'b1010, -1, N + 2);
    idle(1);
    run(4'b0110, -1, -1);
    idle(1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      run(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * N)) : -1, -1);
      idle(int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    @(negedge CK);
    test_reset();
    test_basic();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
